count_readout_fifo: RTL
=======================

// Module: count_readout_fifo
// PURPOSE
//   Buffers 24-bit count words produced by the count pre-buffer stage and serves them to the SPI slave one byte at a time.
//   Sits directly downstream of the pre-buffer (wr_en/count in) and feeds its fifo_level back for flow control.
//   Each word is read MSB byte first. The word is popped only after its third byte is read.
// PARAMETERS
//   DATA_W   24  width of one stored count word; fixed at 3 bytes
//   DEPTH    8   number of word entries; power of two
//   LEVEL_W  4   width of fifo_level; holds 0..DEPTH
// PORTS
//   clk_12mhz   in   1        single system clock; all logic on its rising edge
//   reset_n     in   1        reset, asynchronous, active-low
//   wr_en       in   1        write strobe from pre-buffer; one word per high cycle
//   wr_data     in   DATA_W   count word to store
//   flush       in   1        synchronous clear of contents; from SPI command decoder
//   byte_rd     in   1        one-cycle pulse from SPI slave; consumes current byte
//   byte_out    out  8        current byte of head word (combinational view)
//   byte_valid  out  1        high when byte_out holds real data (FIFO not empty)
//   fifo_level  out  LEVEL_W  stored words, including a partially read head word
//   full        out  1        fifo_level == DEPTH
//   empty       out  1        fifo_level == 0
//   overflow    out  1        sticky: a write was dropped
//   underrun    out  1        sticky: byte_rd arrived while empty
//   clr_flags   in   1        synchronous clear of overflow and underrun
// BEHAVIOUR
//   - Reset (reset_n low, async):
//     - wr_ptr, rd_ptr, byte_idx and level clear to 0.
//     - overflow and underrun clear to 0; empty=1, full=0, byte_valid=0.
//     - byte_out=8'h00; memory contents are don't-care.
//   - Write: wr_en && !full -> mem[wr_ptr] <= wr_data; wr_ptr wraps mod DEPTH; level +1.
//     - Word is visible on byte_out one cycle later if the FIFO was empty.
//   - Write while full with no pop in the same cycle -> word dropped, pointers unchanged, overflow <= 1.
//   - Read:
//     - byte_out = mem[rd_ptr][23:16] / [15:8] / [7:0] for byte_idx = 0 / 1 / 2.
//     - byte_out = 8'h00 when empty.
//   - byte_rd && !empty:
//     - byte_idx 0->1->2 advances.
//     - At byte_idx==2 it returns to 0, rd_ptr wraps mod DEPTH, and level -1 (pop).
//   - byte_rd && empty -> no state change; underrun <= 1.
//   - Simultaneous write and pop:
//     - Both take effect; level unchanged.
//     - A write while full is accepted if a pop occurs in the same cycle.
//   - flush:
//     - Clears pointers, byte_idx and level next cycle; overrides a same-cycle wr_en/byte_rd.
//     - Sticky flags are untouched.
//   - clr_flags:
//     - Clears both sticky flags.
//     - A same-cycle overflow or underrun event wins; the flag stays 1.
//   - fifo_level, full and empty derive from registered level; no extra latency.
// STRUCTURE
//   - Shared include count_defs.vh:
//     - COUNT_W = 24, COUNT_FIFO_DEPTH = 8, COUNT_LEVEL_W = 4.
//     - Byte index encodings BYTE_HI / BYTE_MID / BYTE_LO.
//   - One natural sub-module: count_fifo_mem.
//     - DEPTH x DATA_W register array.
//     - Sync write port, async read port.
//     - Inferable as distributed RAM.
//   - Pointer, level, byte sequencer and flag logic stay in the top module.
// TESTING
//   1. Reset, write 0xA1B2C3, pulse byte_rd x3 -> bytes A1, B2, C3.
//      Level goes 1, 1, 1, then 0; empty=1 after the third pulse.
//   2. Write 8 words 0x000001..0x000008 -> full=1, level=8.
//      A 9th write sets overflow=1, level stays 8.
//      Read all 24 bytes -> words 1..8 in order.
//   3. With level=8 and byte_idx=2, pulse wr_en and byte_rd in the same cycle -> word accepted, overflow stays 0, level=8.
//   4. byte_rd while empty -> byte_out=00, underrun=1.
//      Then clr_flags -> underrun=0.
//   5. Read 1 byte of 0x123456, then flush -> level=0, byte_idx=0.
//      A next write of 0x654321 reads back as 65, 43, 21.
//   6. Drop reset_n mid-word (byte_idx=1, level=3) -> all outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/count_readout_fifo_pkg.sv
// Shared widths and byte-sequencer encodings for the count readout path.
package count_readout_fifo_pkg;

  localparam int COUNT_W          = 24;
  localparam int COUNT_FIFO_DEPTH = 8;
  localparam int COUNT_LEVEL_W    = 4;

  typedef enum logic [1:0] {
    BYTE_HI  = 2'd0,
    BYTE_MID = 2'd1,
    BYTE_LO  = 2'd2
  } byte_idx_t;

  function automatic logic [7:0] select_byte(input logic [COUNT_W-1:0] word,
                                             input byte_idx_t idx);
    logic [7:0] b;
    case (idx)
      BYTE_HI:  b = word[23:16];
      BYTE_MID: b = word[15:8];
      BYTE_LO:  b = word[7:0];
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/count_fifo_mem.sv
// Word storage for the count readout FIFO: sync write, async read.
module count_fifo_mem
  import count_readout_fifo_pkg::*;
#(
  parameter int DATA_W = COUNT_W,
  parameter int DEPTH  = COUNT_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/count_readout_fifo.sv
// Word FIFO between the count pre-buffer and the SPI slave; words are served
// MSB byte first and popped once their last byte has been read.
module count_readout_fifo
  import count_readout_fifo_pkg::*;
#(
  parameter int DATA_W  = COUNT_W,
  parameter int DEPTH   = COUNT_FIFO_DEPTH,
  parameter int LEVEL_W = COUNT_LEVEL_W
) (
  input  logic               clk_12mhz,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               flush,
  input  logic               byte_rd,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underrun,
  input  logic               clr_flags
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level;
  byte_idx_t          byte_idx;
  logic [DATA_W-1:0]  head_word;
  logic               pop;
  logic               wr_acc;
  logic               rd_acc;
  logic               ovf_evt;
  logic               unr_evt;

  assign empty      = (level == '0);
  assign full       = (level == LEVEL_W'(DEPTH));
  assign fifo_level = level;
  assign byte_valid = !empty;
  assign byte_out   = empty ? 8'h00 : select_byte(head_word, byte_idx);

  // A pop in the same cycle frees the slot a write-while-full needs.
  always_comb begin
    rd_acc  = byte_rd && !empty;
    pop     = rd_acc && (byte_idx == BYTE_LO);
    wr_acc  = wr_en && (!full || pop);
    ovf_evt = wr_en && full && !pop;
    unr_evt = byte_rd && empty;
  end

  count_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk_12mhz),
    .we    (wr_acc && !flush),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      byte_idx <= BYTE_HI;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      byte_idx <= BYTE_HI;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) begin
        case (byte_idx)
          BYTE_HI:  byte_idx <= BYTE_MID;
          BYTE_MID: byte_idx <= BYTE_LO;
          default: begin
            byte_idx <= BYTE_HI;
            rd_ptr   <= rd_ptr + PTR_W'(1);
          end
        endcase
      end
      case ({wr_acc, pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // A same-cycle event beats clr_flags so no dropped word goes unreported.
  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (ovf_evt)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (unr_evt)        underrun <= 1'b1;
      else if (clr_flags) underrun <= 1'b0;
    end
  end

endmodule
